// File: rtl/prog_loader_pkg.sv
// Shared types and defaults for the program loader.
package prog_loader_pkg;

    // Sequencer phases: idle, stream program in, hold core reset one cycle, run, report
    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSettle,
        StRun,
        StFinish
    } state_e;

    typedef logic [31:0] word_t;

    localparam int unsigned DefMemWords      = 256;
    localparam int unsigned DefTimeoutCycles = 600;

endpackage

// File: rtl/run_timer.sv
// Run-phase cycle counter with saturation and budget-expiry detection.
module run_timer import prog_loader_pkg::*; #(
    parameter int unsigned LIMIT = DefTimeoutCycles
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  clear,
    input  logic  enable,
    output word_t count,
    output logic  expired
);

    word_t       count_q;
    logic [32:0] count_inc;

    // One extra bit so the compare sees the value this cycle's increment produces
    assign count_inc = {1'b0, count_q} + 33'd1;

    // Count enabled cycles, sticking at all-ones rather than wrapping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != '1)) begin
            count_q <= count_q + 32'd1;
        end
    end

    // Expired in the cycle whose increment reaches the budget, so the
    // caller leaves RUN after exactly LIMIT cycles
    always_comb begin
        expired = 1'b0;
        if (enable) begin
            expired = (count_inc >= {1'b0, LIMIT});
        end
    end

    assign count = count_q;

endmodule

// File: rtl/prog_loader.sv
// Program loader: streams a program into core memory over the out-of-band
// write port, releases the core from reset and supervises it until it halts
// or the run budget expires.
// Optional feature: define PROG_LOADER_CHECKSUM_EN to accumulate a running
// sum of accepted words on the checksum output (otherwise tied to zero).
module prog_loader import prog_loader_pkg::*; #(
    parameter int unsigned MEM_WORDS      = DefMemWords,
    parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(MEM_WORDS):0] load_len,
    input  logic [31:0]                in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [31:0]                oob_wr_addr,
    output logic [31:0]                oob_wr_data,
    output logic                       oob_wen,
    output logic                       comp_rst,
    input  logic                       halt,
    output logic                       busy,
    output logic                       done,
    output logic                       timed_out,
    output logic [31:0]                run_cycles,
    output logic [31:0]                checksum
);

    localparam int unsigned    LenW   = $clog2(MEM_WORDS) + 1;
    localparam logic [LenW-1:0] MaxLen = LenW'(MEM_WORDS);

    state_e          state_q, state_d;
    logic [LenW-1:0] len_clamped;
    logic [LenW-1:0] len_q;
    logic [LenW-1:0] idx_q;
    logic            last_word;
    logic            start_take;
    logic            accept;
    logic            timer_clear;
    logic            timer_en;
    logic            timer_expired;
    word_t           timer_count;
    logic            wen_q;
    word_t           addr_q;
    word_t           data_q;
    logic            done_q;
    logic            timed_out_q;

    assign len_clamped = (load_len > MaxLen) ? MaxLen : load_len;
    assign last_word   = ((idx_q + LenW'(1)) == len_q);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-state control outputs
    always_comb begin
        state_d     = state_q;
        start_take  = 1'b0;
        accept      = 1'b0;
        in_ready    = 1'b0;
        comp_rst    = 1'b1;
        busy        = 1'b0;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        unique case (state_q)
            StIdle, StFinish: begin
                if (start) begin
                    start_take = 1'b1;
                    state_d    = (len_clamped != '0) ? StLoad : StSettle;
                end
            end
            StLoad: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                accept   = in_valid;
                if (in_valid && last_word) begin
                    state_d = StSettle;
                end
            end
            StSettle: begin
                busy        = 1'b1;
                timer_clear = 1'b1;
                state_d     = StRun;
            end
            StRun: begin
                busy     = 1'b1;
                comp_rst = 1'b0;
                timer_en = 1'b1;
                if (halt || timer_expired) begin
                    state_d = StFinish;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Load bookkeeping and the registered memory write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q  <= '0;
            idx_q  <= '0;
            wen_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            wen_q <= accept;
            if (start_take) begin
                len_q <= len_clamped;
                idx_q <= '0;
            end else if (accept) begin
                idx_q  <= idx_q + LenW'(1);
                addr_q <= 32'(idx_q);
                data_q <= in_data;
            end
        end
    end

    // Sticky outcome flags; halt takes priority over a same-cycle expiry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q      <= 1'b0;
            timed_out_q <= 1'b0;
        end else if (start_take) begin
            done_q      <= 1'b0;
            timed_out_q <= 1'b0;
        end else if (state_q == StRun) begin
            if (halt) begin
                done_q <= 1'b1;
            end else if (timer_expired) begin
                timed_out_q <= 1'b1;
            end
        end
    end

    run_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_run_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear | start_take),
        .enable  (timer_en),
        .count   (timer_count),
        .expired (timer_expired)
    );

`ifdef PROG_LOADER_CHECKSUM_EN
    word_t sum_q;

    // Modulo-2^32 running sum of accepted words, restarted with each sequence
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q <= '0;
        end else if (start_take) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= sum_q + in_data;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

    assign oob_wen     = wen_q;
    assign oob_wr_addr = addr_q;
    assign oob_wr_data = data_q;
    assign done        = done_q;
    assign timed_out   = timed_out_q;
    assign run_cycles  = timer_count;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a transaction-level reference model
// compared every cycle, plus hand-computed checks. A second instance with a
// shorter budget shares the stimulus to exercise the timeout paths.
module tb_prog_loader;

    localparam int MW  = 8;
    localparam int TO  = 16;
    localparam int TO2 = 8;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        start    = 1'b0;
    logic        in_valid = 1'b0;
    logic        halt     = 1'b0;
    logic [3:0]  load_len = '0;
    logic [31:0] in_data  = '0;

    logic        in_ready, oob_wen, comp_rst, busy, done, timed_out;
    logic [31:0] oob_wr_addr, oob_wr_data, run_cycles, checksum;

    logic        b_in_ready, b_oob_wen, b_comp_rst, b_busy, b_done, b_timed_out;
    logic [31:0] b_oob_wr_addr, b_oob_wr_data, b_run_cycles, b_checksum;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          c;
    } wr_t;
    wr_t wlog[$];

    // Reference model state
    int          m_ph;  // 0 idle, 1 load, 2 settle, 3 run, 4 finish
    int          m_len, m_cnt, m_runs;
    logic [31:0] m_sum, m_addr, m_data;
    logic        m_wen, m_done, m_to;

    always #5 clk = ~clk;

    prog_loader #(
        .MEM_WORDS      (MW),
        .TIMEOUT_CYCLES (TO)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .load_len    (load_len),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .oob_wr_addr (oob_wr_addr),
        .oob_wr_data (oob_wr_data),
        .oob_wen     (oob_wen),
        .comp_rst    (comp_rst),
        .halt        (halt),
        .busy        (busy),
        .done        (done),
        .timed_out   (timed_out),
        .run_cycles  (run_cycles),
        .checksum    (checksum)
    );

    prog_loader #(
        .MEM_WORDS      (MW),
        .TIMEOUT_CYCLES (TO2)
    ) u_dut_short (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .load_len    (load_len),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (b_in_ready),
        .oob_wr_addr (b_oob_wr_addr),
        .oob_wr_data (b_oob_wr_data),
        .oob_wen     (b_oob_wen),
        .comp_rst    (b_comp_rst),
        .halt        (halt),
        .busy        (b_busy),
        .done        (b_done),
        .timed_out   (b_timed_out),
        .run_cycles  (b_run_cycles),
        .checksum    (b_checksum)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_len = 0; m_cnt = 0; m_runs = 0;
        m_sum = '0; m_addr = '0; m_data = '0;
        m_wen = 1'b0; m_done = 1'b0; m_to = 1'b0;
    endtask

    // One clock of the loader described as a sequence of transactions
    task automatic model_step();
        m_wen = 1'b0;
        case (m_ph)
            0, 4: if (start) begin
                m_done = 1'b0; m_to = 1'b0; m_sum = '0; m_runs = 0; m_cnt = 0;
                m_len  = (int'(load_len) > MW) ? MW : int'(load_len);
                m_ph   = (m_len > 0) ? 1 : 2;
            end
            1: if (in_valid) begin
                m_wen  = 1'b1;
                m_addr = 32'(m_cnt);
                m_data = in_data;
                m_sum  = m_sum + in_data;
                m_cnt++;
                if (m_cnt == m_len) m_ph = 2;
            end
            2: begin
                m_runs = 0;
                m_ph   = 3;
            end
            3: begin
                m_runs++;
                if (halt) begin
                    m_done = 1'b1; m_ph = 4;
                end else if (m_runs >= TO) begin
                    m_to = 1'b1; m_ph = 4;
                end
            end
            default: m_ph = 0;
        endcase
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                chk("in_ready", 32'(in_ready), 32'(m_ph == 1));
                chk("comp_rst", 32'(comp_rst), 32'(m_ph != 3));
                chk("busy", 32'(busy), 32'(m_ph >= 1 && m_ph <= 3));
                chk("oob_wen", 32'(oob_wen), 32'(m_wen));
                chk("oob_wr_addr", oob_wr_addr, m_addr);
                chk("oob_wr_data", oob_wr_data, m_data);
                chk("done", 32'(done), 32'(m_done));
                chk("timed_out", 32'(timed_out), 32'(m_to));
                chk("run_cycles", run_cycles, 32'(m_runs));
`ifdef PROG_LOADER_CHECKSUM_EN
                chk("checksum", checksum, m_sum);
`else
                chk("checksum", checksum, 32'd0);
`endif
                if (oob_wen === 1'b1) wlog.push_back('{oob_wr_addr, oob_wr_data, cyc});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        load_len = 4'(n);
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic wait_run();
        for (int i = 0; i < 100 && m_ph != 3; i++) step();
        chk("run_entry", 32'(m_ph), 32'd3);
    endtask

    task automatic reset_literals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_comp_rst"}, 32'(comp_rst), 32'd1);
        chk({tag, "_oob_wen"}, 32'(oob_wen), 32'd0);
        chk({tag, "_addr"}, oob_wr_addr, 32'd0);
        chk({tag, "_data"}, oob_wr_data, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_timed_out"}, 32'(timed_out), 32'd0);
        chk({tag, "_run_cycles"}, run_cycles, 32'd0);
        chk({tag, "_checksum"}, checksum, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] t1 [4];
        logic        gap [5];
        t1  = '{32'h11, 32'h22, 32'h33, 32'h44};
        gap = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        #2;
        reset_literals("por");
        @(posedge clk); #1;
        rst = 1'b1;
        step(); step();

        // Back-to-back load of four words, then halt on the 10th run cycle
        wlog.delete();
        do_start(4);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = t1[i]; step();
        end
        in_valid = 1'b0;
        chk("t1_settle_comp_rst", 32'(comp_rst), 32'd1);
        chk("t1_settle_busy", 32'(busy), 32'd1);
        step();
        chk("t1_run_comp_rst", 32'(comp_rst), 32'd0);
        chk("t1_nwrites", 32'(wlog.size()), 32'd4);
        if (wlog.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t1_addr", wlog[i].a, 32'(i));
                chk("t1_data", wlog[i].d, t1[i]);
            end
            chk("t1_consecutive", 32'(wlog[3].c - wlog[0].c), 32'd3);
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        chk("t1_checksum", checksum, 32'hAA);
`else
        chk("t1_checksum", checksum, 32'h0);
`endif
        for (int k = 1; k <= 9; k++) begin
            start = (k == 2);  // must be ignored while running
            step();
        end
        start = 1'b0;
        halt  = 1'b1; step(); halt = 1'b0;
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_timed_out", 32'(timed_out), 32'd0);
        chk("t1_run_cycles", run_cycles, 32'd10);
        chk("t1_comp_rst", 32'(comp_rst), 32'd1);
        chk("t1_short_timed_out", 32'(b_timed_out), 32'd1);
        chk("t1_short_done", 32'(b_done), 32'd0);
        chk("t1_short_run_cycles", b_run_cycles, 32'd8);

        // Three words with gaps, halt coinciding with the short budget
        wlog.delete();
        do_start(3);
        for (int i = 0; i < 5; i++) begin
            in_valid = gap[i]; in_data = 32'hA0 + 32'(i); step();
        end
        in_valid = 1'b0;
        step();
        chk("t2_nwrites", 32'(wlog.size()), 32'd3);
        if (wlog.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("t2_addr", wlog[i].a, 32'(i));
                chk("t2_data", wlog[i].d, 32'hA0 + 32'(2 * i));
            end
            chk("t2_gap", 32'(wlog[1].c - wlog[0].c), 32'd2);
        end
        wait_run();
        repeat (7) step();
        halt = 1'b1; step(); halt = 1'b0;
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_run_cycles", run_cycles, 32'd8);
        chk("t2_short_done", 32'(b_done), 32'd1);
        chk("t2_short_timed_out", 32'(b_timed_out), 32'd0);
        chk("t2_short_run_cycles", b_run_cycles, 32'd8);

        // Zero-length start from FINISH, never halts
        do_start(0);
        chk("t3_done_cleared", 32'(done), 32'd0);
        chk("t3_busy", 32'(busy), 32'd1);
        wait_run();
        repeat (20) step();
        chk("t3_timed_out", 32'(timed_out), 32'd1);
        chk("t3_done", 32'(done), 32'd0);
        chk("t3_run_cycles", run_cycles, 32'd16);
        chk("t3_short_timed_out", 32'(b_timed_out), 32'd1);
        chk("t3_short_run_cycles", b_run_cycles, 32'd8);

        // Reset after two of five words, then a one-word program
        do_start(5);
        in_valid = 1'b1; in_data = 32'h5; step();
        in_data  = 32'h6; step();
        in_valid = 1'b0;
        wlog.delete();
        #2 rst = 1'b0;
        #1 reset_literals("t4_rst");
        @(posedge clk); #1;
        rst = 1'b1;
        step();
        do_start(1);
        in_valid = 1'b1; in_data = 32'hBEEF; step();
        in_valid = 1'b0;
        step();
        chk("t4_nwrites", 32'(wlog.size()), 32'd1);
        if (wlog.size() == 1) begin
            chk("t4_addr", wlog[0].a, 32'd0);
            chk("t4_data", wlog[0].d, 32'hBEEF);
        end
        wait_run();
        halt = 1'b1; step(); halt = 1'b0;
        chk("t4_run_cycles", run_cycles, 32'd1);

        // Oversized length is clamped to the memory size
        wlog.delete();
        do_start(MW + 5);
        for (int i = 0; i < MW + 5; i++) begin
            in_valid = 1'b1; in_data = 32'h100 + 32'(i); step();
        end
        in_valid = 1'b0;
        step();
        chk("t5_nwrites", 32'(wlog.size()), 32'(MW));
        if (wlog.size() == MW) begin
            chk("t5_last_addr", wlog[MW-1].a, 32'(MW - 1));
            chk("t5_last_data", wlog[MW-1].d, 32'h107);
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        chk("t5_checksum", checksum, 32'h81C);
`else
        chk("t5_checksum", checksum, 32'h0);
`endif
        wait_run();
        halt = 1'b1; step(); halt = 1'b0;
        chk("t5_done", 32'(done), 32'd1);
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
